// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter sharing one bus_protocol slave port among NUM_MASTERS masters.
// One transaction in flight at a time; a silent slave is answered with an error after a timeout.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_MASTERS-1:0]              m_req_valid_i,
    input  logic [NUM_MASTERS-1:0]              m_req_write_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_req_addr_i,
    input  logic [NUM_MASTERS*ID_WIDTH-1:0]     m_req_id_i,
    output logic [NUM_MASTERS-1:0]              m_req_ready_o,
    input  logic [NUM_MASTERS-1:0]              m_data_valid_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_data_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_data_strb_i,
    output logic [NUM_MASTERS-1:0]              m_data_ready_o,
    output logic [NUM_MASTERS-1:0]              m_resp_valid_o,
    output logic [NUM_MASTERS-1:0]              m_resp_error_o,
    output logic [DATA_WIDTH-1:0]               m_resp_data_o,
    output logic [ID_WIDTH-1:0]                 m_resp_id_o,
    input  logic [NUM_MASTERS-1:0]              m_resp_ready_i,
    output logic                                s_req_valid_o,
    output logic [ADDR_WIDTH-1:0]               s_req_addr_o,
    output logic                                s_req_write_o,
    output logic [ID_WIDTH-1:0]                 s_req_id_o,
    input  logic                                s_req_ready_i,
    output logic                                s_data_valid_o,
    output logic [DATA_WIDTH-1:0]               s_data_o,
    output logic [DATA_WIDTH/8-1:0]             s_data_strb_o,
    input  logic                                s_data_ready_i,
    input  logic                                s_resp_valid_i,
    input  logic [DATA_WIDTH-1:0]               s_resp_data_i,
    input  logic [ID_WIDTH-1:0]                 s_resp_id_i,
    input  logic                                s_resp_error_i,
    output logic                                s_resp_ready_o,
    output logic [$clog2(NUM_MASTERS)-1:0]      grant_o,
    output logic                                busy_o,
    output logic                                stray_resp_o
);

    localparam int GW    = $clog2(NUM_MASTERS);
    localparam int SW    = DATA_WIDTH / 8;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W:0] TO_VAL = (CNT_W + 1)'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_TOUT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GW-1:0]      r_grant;
    logic [GW-1:0]      r_last;
    logic [GW-1:0]      w_pick;
    logic [ID_WIDTH-1:0] r_id;
    logic               r_write;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W:0]     w_cnt_inc;
    logic               r_stray;
    logic               w_resp_done;
    int                 w_best;
    int                 w_dist;

    logic [ADDR_WIDTH-1:0] w_addr [NUM_MASTERS];
    logic [ID_WIDTH-1:0]   w_id   [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] w_data [NUM_MASTERS];
    logic [SW-1:0]         w_strb [NUM_MASTERS];

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
        assign w_addr[k] = m_req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_id[k]   = m_req_id_i[k*ID_WIDTH +: ID_WIDTH];
        assign w_data[k] = m_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        assign w_strb[k] = m_data_strb_i[k*SW +: SW];
    end

    // Requester with the smallest distance after the last grant wins.
    always_comb begin
        w_pick = '0;
        w_best = NUM_MASTERS;
        w_dist = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_dist = (k + NUM_MASTERS - 1 - int'(r_last)) % NUM_MASTERS;
            if (m_req_valid_i[k] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_pick = GW'(k);
            end
        end
    end

    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        m_req_ready_o  = '0;
        m_data_ready_o = '0;
        m_resp_valid_o = '0;
        m_resp_error_o = '0;
        m_resp_data_o  = '0;
        m_resp_id_o    = '0;
        s_req_valid_o  = 1'b0;
        s_req_addr_o   = '0;
        s_req_write_o  = 1'b0;
        s_req_id_o     = '0;
        s_data_valid_o = 1'b0;
        s_data_o       = '0;
        s_data_strb_o  = '0;
        s_resp_ready_o = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                s_resp_ready_o = 1'b1;
                if (|m_req_valid_i) begin
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                s_resp_ready_o         = 1'b1;
                s_req_valid_o          = 1'b1;
                s_req_addr_o           = w_addr[r_grant];
                s_req_write_o          = m_req_write_i[r_grant];
                s_req_id_o             = w_id[r_grant];
                m_req_ready_o[r_grant] = s_req_ready_i;
                if (s_req_ready_i) begin
                    w_state_nxt = r_write ? S_DATA : S_RESP;
                    w_cnt_nxt   = '0;
                end
            end
            S_DATA: begin
                s_resp_ready_o          = 1'b1;
                s_data_valid_o          = m_data_valid_i[r_grant];
                m_data_ready_o[r_grant] = s_data_ready_i;
                if (m_data_valid_i[r_grant]) begin
                    s_data_o      = w_data[r_grant];
                    s_data_strb_o = w_strb[r_grant];
                    if (s_data_ready_i) begin
                        w_state_nxt = S_RESP;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            S_RESP: begin
                s_resp_ready_o          = m_resp_ready_i[r_grant];
                m_resp_valid_o[r_grant] = s_resp_valid_i;
                if (s_resp_valid_i) begin
                    m_resp_error_o[r_grant] = s_resp_error_i | (s_resp_id_i != r_id);
                    m_resp_data_o           = s_resp_data_i;
                    m_resp_id_o             = s_resp_id_i;
                    if (m_resp_ready_i[r_grant]) begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
                    if ((TIMEOUT_CYCLES != 0) && (w_cnt_inc == TO_VAL)) begin
                        w_state_nxt = S_TOUT;
                    end
                end
            end
            S_TOUT: begin
                m_resp_valid_o[r_grant] = 1'b1;
                m_resp_error_o[r_grant] = 1'b1;
                m_resp_id_o             = r_id;
                if (m_resp_ready_i[r_grant]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_resp_done = ((r_state == S_RESP) && s_resp_valid_i && m_resp_ready_i[r_grant]) ||
                         ((r_state == S_TOUT) && m_resp_ready_i[r_grant]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= GW'(NUM_MASTERS - 1);
            r_cnt   <= '0;
            r_stray <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Outside RESP/TOUT the slave response channel is always accepted and discarded.
            r_stray <= s_resp_valid_i &&
                       ((r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA));
            if ((r_state == S_IDLE) && (|m_req_valid_i)) begin
                r_grant <= w_pick;
            end
            if (w_resp_done) begin
                r_last <= r_grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE) begin
            r_id    <= w_id[w_pick];
            r_write <= m_req_write_i[w_pick];
        end
    end

    assign grant_o      = r_grant;
    assign busy_o       = (r_state != S_IDLE);
    assign stray_resp_o = r_stray;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Randomised bench for bus_arbiter_rr: a transaction-level master/slave model predicts
// round-robin grants, channel forwarding, response routing, timeouts and stray pulses.
module tb_bus_arbiter_rr;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int SW = DW / 8;
    localparam int TO = 8;
    localparam int GW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_req_valid_i, m_req_write_i, m_req_ready_o;
    logic [N*AW-1:0] m_req_addr_i;
    logic [N*IW-1:0] m_req_id_i;
    logic [N-1:0]    m_data_valid_i, m_data_ready_o;
    logic [N*DW-1:0] m_data_i;
    logic [N*SW-1:0] m_data_strb_i;
    logic [N-1:0]    m_resp_valid_o, m_resp_error_o, m_resp_ready_i;
    logic [DW-1:0]   m_resp_data_o;
    logic [IW-1:0]   m_resp_id_o;
    logic            s_req_valid_o, s_req_write_o, s_req_ready_i;
    logic [AW-1:0]   s_req_addr_o;
    logic [IW-1:0]   s_req_id_o;
    logic            s_data_valid_o, s_data_ready_i;
    logic [DW-1:0]   s_data_o;
    logic [SW-1:0]   s_data_strb_o;
    logic            s_resp_valid_i, s_resp_error_i, s_resp_ready_o;
    logic [DW-1:0]   s_resp_data_i;
    logic [IW-1:0]   s_resp_id_i;
    logic [GW-1:0]   grant_o;
    logic            busy_o, stray_resp_o;

    always #5 clk = ~clk;

    bus_arbiter_rr #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req_valid_i(m_req_valid_i), .m_req_write_i(m_req_write_i),
        .m_req_addr_i(m_req_addr_i), .m_req_id_i(m_req_id_i), .m_req_ready_o(m_req_ready_o),
        .m_data_valid_i(m_data_valid_i), .m_data_i(m_data_i), .m_data_strb_i(m_data_strb_i),
        .m_data_ready_o(m_data_ready_o),
        .m_resp_valid_o(m_resp_valid_o), .m_resp_error_o(m_resp_error_o),
        .m_resp_data_o(m_resp_data_o), .m_resp_id_o(m_resp_id_o), .m_resp_ready_i(m_resp_ready_i),
        .s_req_valid_o(s_req_valid_o), .s_req_addr_o(s_req_addr_o), .s_req_write_o(s_req_write_o),
        .s_req_id_o(s_req_id_o), .s_req_ready_i(s_req_ready_i),
        .s_data_valid_o(s_data_valid_o), .s_data_o(s_data_o), .s_data_strb_o(s_data_strb_o),
        .s_data_ready_i(s_data_ready_i),
        .s_resp_valid_i(s_resp_valid_i), .s_resp_data_i(s_resp_data_i), .s_resp_id_i(s_resp_id_i),
        .s_resp_error_i(s_resp_error_i), .s_resp_ready_o(s_resp_ready_o),
        .grant_o(grant_o), .busy_o(busy_o), .stray_resp_o(stray_resp_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    int last_g;

    logic [AW-1:0] t_addr [N];
    logic [IW-1:0] t_id   [N];
    logic [DW-1:0] t_data [N];
    logic [SW-1:0] t_strb [N];
    logic [N-1:0]  t_wr, req_on, dat_on;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] oh(input int g);
        return N'(1) << g;
    endfunction

    // Spec rule: first requester at or after (last+1) mod N.
    function automatic int rr_pick(input logic [N-1:0] pend, input int last);
        for (int i = 1; i <= N; i++) begin
            if ((pend & oh((last + i) % N)) != '0) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic drive_masters();
        for (int k = 0; k < N; k++) begin
            m_req_addr_i[k*AW +: AW]  = t_addr[k];
            m_req_id_i[k*IW +: IW]    = t_id[k];
            m_data_i[k*DW +: DW]      = t_data[k];
            m_data_strb_i[k*SW +: SW] = t_strb[k];
        end
        m_req_valid_i  = req_on;
        m_req_write_i  = t_wr;
        m_data_valid_i = dat_on;
    endtask

    task automatic new_req(input int k, input logic wr);
        t_addr[k] = $urandom;
        t_id[k]   = IW'($urandom);
        t_data[k] = $urandom;
        t_strb[k] = SW'($urandom);
        t_wr      = wr ? (t_wr | oh(k)) : (t_wr & ~oh(k));
        req_on    = req_on | oh(k);
        dat_on    = wr ? (dat_on | oh(k)) : (dat_on & ~oh(k));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_grant"}, grant_o, 0);
        chk({tag, "_stray"}, stray_resp_o, 0);
        chk({tag, "_sreqv"}, s_req_valid_o, 0);
        chk({tag, "_saddr"}, s_req_addr_o, 0);
        chk({tag, "_sdatv"}, s_data_valid_o, 0);
        chk({tag, "_sdata"}, s_data_o, 0);
        chk({tag, "_mreqr"}, m_req_ready_o, 0);
        chk({tag, "_mdatr"}, m_data_ready_o, 0);
        chk({tag, "_mrspv"}, m_resp_valid_o, 0);
        chk({tag, "_mrspe"}, m_resp_error_o, 0);
        chk({tag, "_mrspd"}, m_resp_data_o, 0);
        chk({tag, "_srspr"}, s_resp_ready_o, 1);
    endtask

    // Starts at a negedge with the DUT idle and req_on driven; ends at the negedge after completion.
    task automatic run_txn(input int addr_st, input int data_st, input int resp_dly, input int mrdy_st,
                           input logic silent, input logic [IW-1:0] rid_xor, input logic slv_err,
                           input logic stray, input logic [DW-1:0] rdata);
        int            g;
        logic [N-1:0]  gm;
        logic [IW-1:0] eid;
        logic          eerr;
        g   = rr_pick(req_on, last_g);
        gm  = oh(g);
        eid = t_id[g];
        chk("idle_busy", busy_o, 0);
        chk("idle_srr", s_resp_ready_o, 1);
        chk("idle_rspv", m_resp_valid_o, 0);
        s_resp_valid_i = stray;
        @(negedge clk);
        s_resp_valid_i = 1'b0;
        chk("stray", stray_resp_o, stray);
        chk("grant", grant_o, g);
        chk("busy", busy_o, 1);
        for (int i = 0; i <= addr_st; i++) begin
            s_req_ready_i  = (i == addr_st);
            s_data_ready_i = (i == addr_st) ? 1'b0 : 1'($urandom);
            #1;
            chk("sreq_valid", s_req_valid_o, 1);
            chk("sreq_addr", s_req_addr_o, t_addr[g]);
            chk("sreq_write", s_req_write_o, (t_wr & gm) != '0);
            chk("sreq_id", s_req_id_o, eid);
            chk("mreq_ready", m_req_ready_o, s_req_ready_i ? gm : '0);
            chk("addr_mdatr", m_data_ready_o, 0);
            chk("addr_sdatv", s_data_valid_o, 0);
            @(negedge clk);
        end
        s_req_ready_i  = 1'b0;
        s_data_ready_i = 1'b0;
        req_on         = req_on & ~gm;
        drive_masters();
        if ((t_wr & gm) != '0) begin
            for (int i = 0; i <= data_st; i++) begin
                s_data_ready_i = (i == data_st);
                #1;
                chk("sdat_valid", s_data_valid_o, 1);
                chk("sdat_data", s_data_o, t_data[g]);
                chk("sdat_strb", s_data_strb_o, t_strb[g]);
                chk("mdat_ready", m_data_ready_o, s_data_ready_i ? gm : '0);
                chk("data_sreqv", s_req_valid_o, 0);
                @(negedge clk);
            end
            s_data_ready_i = 1'b0;
            dat_on         = dat_on & ~gm;
            drive_masters();
        end
        if (silent) begin
            for (int i = 0; i < TO; i++) begin
                m_resp_ready_i = N'($urandom);
                #1;
                chk("wait_rspv", m_resp_valid_o, 0);
                chk("wait_busy", busy_o, 1);
                chk("wait_srr", s_resp_ready_o, (m_resp_ready_i & gm) != '0);
                @(negedge clk);
            end
            for (int i = 0; i <= mrdy_st; i++) begin
                m_resp_ready_i = (N'($urandom) & ~gm) | ((i == mrdy_st) ? gm : '0);
                #1;
                chk("tout_rspv", m_resp_valid_o, gm);
                chk("tout_err", m_resp_error_o, gm);
                chk("tout_data", m_resp_data_o, 0);
                chk("tout_id", m_resp_id_o, eid);
                chk("tout_srr", s_resp_ready_o, 0);
                @(negedge clk);
            end
        end else begin
            for (int i = 0; i < resp_dly; i++) begin
                m_resp_ready_i = N'($urandom);
                #1;
                chk("dly_rspv", m_resp_valid_o, 0);
                @(negedge clk);
            end
            eerr           = slv_err | (rid_xor != '0);
            s_resp_valid_i = 1'b1;
            s_resp_data_i  = rdata;
            s_resp_id_i    = eid ^ rid_xor;
            s_resp_error_i = slv_err;
            for (int i = 0; i <= mrdy_st; i++) begin
                m_resp_ready_i = (N'($urandom) & ~gm) | ((i == mrdy_st) ? gm : '0);
                #1;
                chk("rsp_valid", m_resp_valid_o, gm);
                chk("rsp_error", m_resp_error_o, eerr ? gm : '0);
                chk("rsp_data", m_resp_data_o, rdata);
                chk("rsp_id", m_resp_id_o, eid ^ rid_xor);
                chk("rsp_srr", s_resp_ready_o, i == mrdy_st);
                @(negedge clk);
            end
            s_resp_valid_i = 1'b0;
            s_resp_data_i  = '0;
            s_resp_id_i    = '0;
            s_resp_error_i = 1'b0;
        end
        m_resp_ready_i = '0;
        last_g         = g;
    endtask

    initial begin
        rst = 1'b1;
        m_resp_ready_i = '0;
        s_req_ready_i  = 1'b0;
        s_data_ready_i = 1'b0;
        s_resp_valid_i = 1'b0;
        s_resp_data_i  = '0;
        s_resp_id_i    = '0;
        s_resp_error_i = 1'b0;
        req_on = '0;
        dat_on = '0;
        t_wr   = '0;
        for (int k = 0; k < N; k++) begin
            t_addr[k] = '0;
            t_id[k]   = '0;
            t_data[k] = '0;
            t_strb[k] = '0;
        end
        drive_masters();
        last_g = N - 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst0");
        rst = 1'b0;
        @(negedge clk);

        // Master 0 read, slave answers with matching ID after a short wait.
        new_req(0, 1'b0);
        t_addr[0] = 32'h1234_5678;
        t_id[0]   = 4'd1;
        drive_masters();
        run_txn(0, 0, 2, 0, 1'b0, '0, 1'b0, 1'b0, 32'h1234_5678);

        // Master 1 write with a two-cycle data stall.
        new_req(1, 1'b1);
        t_addr[1] = 32'h0000_2222;
        t_id[1]   = 4'd4;
        t_data[1] = 32'hDEAD_BEEF;
        t_strb[1] = 4'hF;
        drive_masters();
        run_txn(0, 2, 0, 0, 1'b0, '0, 1'b0, 1'b0, 32'h0000_0000);

        // Master 2 read ID 3; slave answers ID 5.
        new_req(2, 1'b0);
        t_id[2] = 4'd3;
        drive_masters();
        run_txn(0, 0, 1, 1, 1'b0, 4'd3 ^ 4'd5, 1'b0, 1'b0, 32'hCAFE_F00D);

        // Silent slave, then a late response arriving in IDLE.
        new_req(0, 1'b0);
        drive_masters();
        run_txn(1, 0, 0, 2, 1'b1, '0, 1'b0, 1'b0, '0);
        new_req(1, 1'b0);
        drive_masters();
        run_txn(0, 0, 0, 0, 1'b0, '0, 1'b1, 1'b1, 32'h5555_AAAA);

        // All masters requesting continuously, zero-wait slave.
        req_on = '0;
        dat_on = '0;
        for (int k = 0; k < N; k++) new_req(k, 1'b0);
        drive_masters();
        for (int t = 0; t < 3 * N; t++) begin
            run_txn(0, 0, 0, 0, 1'b0, '0, 1'b0, 1'b0, $urandom);
            new_req(last_g, 1'b0);
            drive_masters();
        end

        // Randomised traffic.
        for (int t = 0; t < 60; t++) begin
            for (int k = 0; k < N; k++) begin
                if (((req_on & oh(k)) == '0) && ($urandom_range(0, 1) == 1)) new_req(k, 1'($urandom));
            end
            if (req_on == '0) new_req($urandom_range(0, N - 1), 1'($urandom));
            drive_masters();
            run_txn($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3),
                    $urandom_range(0, 2), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 4) == 0) ? IW'($urandom_range(1, 15)) : '0,
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0), $urandom);
        end

        // Reset while in the DATA phase.
        req_on = '0;
        dat_on = '0;
        drive_masters();
        @(negedge clk);
        new_req(1, 1'b1);
        drive_masters();
        @(negedge clk);
        s_req_ready_i = 1'b1;
        @(negedge clk);
        s_req_ready_i = 1'b0;
        req_on = '0;
        drive_masters();
        #1;
        chk("pre_rst_sdatv", s_data_valid_o, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst1");
        rst    = 1'b0;
        dat_on = '0;
        last_g = N - 1;
        new_req(0, 1'b0);
        new_req(1, 1'b0);
        drive_masters();
        run_txn(0, 0, 0, 0, 1'b0, '0, 1'b0, 1'b0, 32'h0BAD_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
